// File: rtl/cache_responder.sv
// cache_responder -- single-outstanding-access bridge from the datapath's
// instruction and data request ports to a word-addressed RAM.
//
// Data requests always win over instruction requests. Each access latches
// its word-aligned address, store data and operation, holds exactly one RAM
// strobe until ramready (or a TIMEOUT-cycle wait limit), strobes a one-cycle
// hit, then passes through DONE for one cycle so that a request still held
// high is not served twice.
//
// Optional feature: define IFETCH_HOLD_EN to keep one entry holding the last
// successful instruction fetch. A repeat fetch of that word is answered
// combinationally from IDLE without a RAM access. Any completed write to
// that word invalidates the entry.
//
// Parameters:
//   TIMEOUT    maximum RAM wait cycles per access (1..255)
// Ports:
//   CLK        system clock, rising-edge state updates
//   RST        synchronous active-high reset
//   halt       blocks new instruction fetches (in-flight fetches finish)
//   imemREN    instruction read request, imemaddr its byte address
//   dmemREN    data read request, dmemWEN data write request
//   dmemaddr   data byte address, dmemstore store data
//   ihit/dhit  one-cycle completion strobes
//   imemload   instruction word, valid while ihit is high (else 0)
//   dmemload   data word, valid while dhit is high (0 for writes)
//   ramaddr    RAM word address, ramstore RAM write data
//   ramREN     RAM read strobe, ramWEN RAM write strobe
//   ramload    RAM read data, ramready RAM access complete
//   err        sticky timeout flag
module cache_responder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] imemload,
  output logic [31:0] dmemload,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ramREN,
  output logic        ramWEN,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, DACC, IACC, DONE} state_t;

  localparam logic [7:0]  LAST_WAIT    = 8'(TIMEOUT - 1);
  localparam logic [31:0] TIMEOUT_WORD = 32'hBAD1_BAD1;
  localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic        write_q;
  logic        dropped_q;
  logic        ren_q;
  logic        wen_q;
  logic        err_q;

  logic        in_acc;
  logic        data_req;
  logic        req_live;
  logic        timed_out;
  logic        finish;
  logic        serve;
  logic        hold_hit;
  logic [31:0] hold_word;

  always_comb begin
    in_acc    = (state == DACC) || (state == IACC);
    data_req  = dmemREN || dmemWEN;
    req_live  = (state == DACC) ? data_req : imemREN;
    timed_out = in_acc && !ramready && (wait_cnt == LAST_WAIT);
    finish    = in_acc && (ramready || timed_out);
    // A request that dropped at any point during the access loses its hit.
    serve     = finish && req_live && !dropped_q;
  end

`ifdef IFETCH_HOLD_EN
  logic        hold_valid;
  logic [31:0] hold_addr;
  logic [31:0] hold_data;

  always_comb begin
    hold_word = hold_data;
    hold_hit  = (state == IDLE) && imemREN && !halt && !data_req && hold_valid &&
                ((imemaddr & WORD_MASK) == hold_addr);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
    end else if ((state == IACC) && serve && !timed_out) begin
      hold_valid <= 1'b1;
      hold_addr  <= addr_q;
      hold_data  <= ramload;
    end else if ((state == DACC) && finish && write_q && (addr_q == hold_addr)) begin
      hold_valid <= 1'b0;
    end
  end
`else
  always_comb begin
    hold_word = '0;
    hold_hit  = 1'b0;
  end
`endif

  always_comb begin
    ihit     = ((state == IACC) && serve) || hold_hit;
    dhit     = (state == DACC) && serve;
    imemload = '0;
    if (hold_hit)
      imemload = hold_word;
    else if ((state == IACC) && serve)
      imemload = timed_out ? TIMEOUT_WORD : ramload;
    dmemload = '0;
    if (dhit)
      dmemload = timed_out ? TIMEOUT_WORD : (write_q ? '0 : ramload);
    ramaddr  = in_acc ? addr_q : '0;
    ramstore = in_acc ? store_q : '0;
    // A timed-out access releases the RAM in its final cycle.
    ramREN   = ren_q && !timed_out;
    ramWEN   = wen_q && !timed_out;
    err      = err_q || timed_out;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      addr_q    <= '0;
      store_q   <= '0;
      write_q   <= 1'b0;
      dropped_q <= 1'b0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt  <= '0;
          dropped_q <= 1'b0;
          if (data_req) begin
            state   <= DACC;
            addr_q  <= dmemaddr & WORD_MASK;
            store_q <= dmemstore;
            write_q <= dmemWEN;
            wen_q   <= dmemWEN;
            ren_q   <= !dmemWEN;
          end else if (imemREN && !halt && !hold_hit) begin
            state   <= IACC;
            addr_q  <= imemaddr & WORD_MASK;
            store_q <= '0;
            write_q <= 1'b0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b1;
          end
        end
        DACC, IACC: begin
          if (finish) begin
            state <= DONE;
            ren_q <= 1'b0;
            wen_q <= 1'b0;
            if (timed_out)
              err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (!req_live)
              dropped_q <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_responder.sv
module tb_cache_responder;

  logic        CLK = 1'b0;
  logic        RST, halt, imemREN, dmemREN, dmemWEN, ramready;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  cache_responder #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramready(ramready), .err(err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard and compare the returned word against it.
  task automatic sb_chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_0000;
    chk(tag, obs, e);
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      n_checks++;
      assert (!(ihit === 1'b1 && dhit === 1'b1)) else begin
        n_fail++;
        $error("FAIL hit_exclusive: observed ihit=%b dhit=%b expected not both", ihit, dhit);
      end
    end
  end

  initial begin
    RST = 1'b1; halt = 1'b0; imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    ramready = 1'b0; imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramload = '0;
    adv(); adv();
    RST = 1'b0;
    settle();
    chk("rst_ihit", 32'(ihit), 0);
    chk("rst_dhit", 32'(dhit), 0);
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramWEN", 32'(ramWEN), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_err", 32'(err), 0);

    // Simultaneous data and instruction read: data first.
    adv();
    dmemREN = 1'b1; dmemaddr = 32'h0000_0200;
    imemREN = 1'b1; imemaddr = 32'h0000_0300;
    exp_q.push_back(32'hD0D0_0001);
    exp_q.push_back(32'h1357_0001);
    settle();
    chk("prio_idle_dhit", 32'(dhit), 0);
    chk("prio_idle_ihit", 32'(ihit), 0);
    adv();
    settle();
    chk("prio_c1_ramREN", 32'(ramREN), 1);
    chk("prio_c1_ramWEN", 32'(ramWEN), 0);
    chk("prio_c1_ramaddr", ramaddr, 32'h0000_0200);
    chk("prio_c1_dhit", 32'(dhit), 0);
    adv();
    settle();
    chk("prio_c2_dhit", 32'(dhit), 0);
    adv();
    ramready = 1'b1; ramload = 32'hD0D0_0001;
    settle();
    chk("prio_c3_dhit", 32'(dhit), 1);
    sb_chk("prio_c3_dmemload", dmemload);
    adv();
    ramready = 1'b0; ramload = '0; dmemREN = 1'b0;
    settle();
    chk("prio_done_ramREN", 32'(ramREN), 0);
    chk("prio_done_dhit", 32'(dhit), 0);
    chk("prio_done_ihit", 32'(ihit), 0);
    adv();
    settle();
    chk("prio_idle2_ramREN", 32'(ramREN), 0);
    chk("prio_idle2_ihit", 32'(ihit), 0);
    adv();
    settle();
    chk("ifetch_c1_ramREN", 32'(ramREN), 1);
    chk("ifetch_c1_ramaddr", ramaddr, 32'h0000_0300);
    adv();
    ramready = 1'b1; ramload = 32'h1357_0001;
    settle();
    chk("ifetch_ihit", 32'(ihit), 1);
    sb_chk("ifetch_imemload", imemload);
    adv();
    ramready = 1'b0; imemREN = 1'b0;
    adv();

    // Write with both data strobes high, unaligned address.
    dmemWEN = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h0000_0043; dmemstore = 32'h1234_5678;
    exp_q.push_back(32'h0000_0000);
    adv();
    settle();
    chk("wr_ramWEN", 32'(ramWEN), 1);
    chk("wr_ramREN", 32'(ramREN), 0);
    chk("wr_ramaddr", ramaddr, 32'h0000_0040);
    chk("wr_ramstore", ramstore, 32'h1234_5678);
    adv();
    ramready = 1'b1; ramload = 32'hFFFF_FFFF;
    settle();
    chk("wr_dhit", 32'(dhit), 1);
    sb_chk("wr_dmemload", dmemload);
    adv();
    ramready = 1'b0; ramload = '0; dmemWEN = 1'b0; dmemREN = 1'b0;
    adv();

    // Instruction request dropped mid-access: no hit.
    imemREN = 1'b1; imemaddr = 32'h0000_0500;
    adv();
    settle();
    chk("drop_c1_ramREN", 32'(ramREN), 1);
    adv();
    imemREN = 1'b0; ramready = 1'b1; ramload = 32'h0000_ABCD;
    settle();
    chk("drop_c2_ihit", 32'(ihit), 0);
    chk("drop_c2_imemload", imemload, 0);
    adv();
    ramready = 1'b0;
    settle();
    chk("drop_done_ramREN", 32'(ramREN), 0);
    chk("drop_done_ihit", 32'(ihit), 0);
    adv();

    // halt during IACC does not abort; afterwards it blocks new fetches.
    imemREN = 1'b1; imemaddr = 32'h0000_0600;
    exp_q.push_back(32'h6666_0600);
    adv();
    halt = 1'b1;
    adv();
    ramready = 1'b1; ramload = 32'h6666_0600;
    settle();
    chk("halt_ihit", 32'(ihit), 1);
    sb_chk("halt_imemload", imemload);
    adv();
    ramready = 1'b0;
    adv();
    settle();
    chk("halt_idle_ihit", 32'(ihit), 0);
    adv();
    settle();
    chk("halt_block_ramREN", 32'(ramREN), 0);
    adv();
    settle();
    chk("halt_block2_ramREN", 32'(ramREN), 0);
    halt = 1'b0; imemREN = 1'b0;
    adv();

    // Fetch 0x100 through the RAM, then fetch it again.
    imemREN = 1'b1; imemaddr = 32'h0000_0100;
    exp_q.push_back(32'h1111_0100);
    adv();
    ramready = 1'b1; ramload = 32'h1111_0100;
    settle();
    chk("f100a_ihit", 32'(ihit), 1);
    sb_chk("f100a_imemload", imemload);
    adv();
    ramready = 1'b0; ramload = '0; imemREN = 1'b0;
    adv();
    imemREN = 1'b1; imemaddr = 32'h0000_0100;
    exp_q.push_back(32'h1111_0100);
`ifdef IFETCH_HOLD_EN
    settle();
    chk("hold_ihit", 32'(ihit), 1);
    chk("hold_ramREN", 32'(ramREN), 0);
    sb_chk("hold_imemload", imemload);
    adv();
    imemREN = 1'b0;
    settle();
    chk("hold_stay_ramREN", 32'(ramREN), 0);
    // Write to the held word invalidates it.
    adv();
    dmemWEN = 1'b1; dmemaddr = 32'h0000_0100; dmemstore = 32'h2222_0100;
    exp_q.push_back(32'h0000_0000);
    adv();
    ramready = 1'b1;
    settle();
    chk("inv_wr_dhit", 32'(dhit), 1);
    sb_chk("inv_wr_dmemload", dmemload);
    adv();
    ramready = 1'b0; dmemWEN = 1'b0;
    adv();
    imemREN = 1'b1; imemaddr = 32'h0000_0102;
    exp_q.push_back(32'h2222_0100);
    settle();
    chk("inv_idle_ihit", 32'(ihit), 0);
    adv();
    settle();
    chk("inv_iacc_ramREN", 32'(ramREN), 1);
    chk("inv_iacc_ramaddr", ramaddr, 32'h0000_0100);
    ramready = 1'b1; ramload = 32'h2222_0100;
    settle();
    chk("inv_ihit", 32'(ihit), 1);
    sb_chk("inv_imemload", imemload);
    adv();
    ramready = 1'b0; ramload = '0; imemREN = 1'b0;
    adv();
`else
    settle();
    chk("nohold_idle_ihit", 32'(ihit), 0);
    adv();
    settle();
    chk("nohold_ramREN", 32'(ramREN), 1);
    chk("nohold_ramaddr", ramaddr, 32'h0000_0100);
    adv();
    ramready = 1'b1; ramload = 32'h1111_0100;
    settle();
    chk("nohold_ihit", 32'(ihit), 1);
    sb_chk("nohold_imemload", imemload);
    adv();
    ramready = 1'b0; ramload = '0; imemREN = 1'b0;
    adv();
`endif

    // Timeout with ramready stuck low.
    adv();
    dmemREN = 1'b1; dmemaddr = 32'h0000_0700;
    exp_q.push_back(32'hBAD1_BAD1);
    adv();
    settle();
    chk("to_c1_dhit", 32'(dhit), 0);
    adv();
    settle();
    chk("to_c2_dhit", 32'(dhit), 0);
    adv();
    settle();
    chk("to_c3_dhit", 32'(dhit), 0);
    chk("to_c3_err", 32'(err), 0);
    adv();
    settle();
    chk("to_c4_dhit", 32'(dhit), 1);
    chk("to_c4_err", 32'(err), 1);
    sb_chk("to_c4_dmemload", dmemload);
    adv();
    dmemREN = 1'b0;
    settle();
    chk("to_done_ramREN", 32'(ramREN), 0);
    chk("to_done_err", 32'(err), 1);
    adv();
    // A later successful access leaves err set.
    adv();
    dmemREN = 1'b1; dmemaddr = 32'h0000_0704;
    exp_q.push_back(32'h7777_0704);
    adv();
    ramready = 1'b1; ramload = 32'h7777_0704;
    settle();
    chk("after_to_dhit", 32'(dhit), 1);
    sb_chk("after_to_dmemload", dmemload);
    adv();
    ramready = 1'b0; dmemREN = 1'b0;
    adv();
    settle();
    chk("after_to_err", 32'(err), 1);

    // Reset in the middle of a data access.
    adv();
    dmemREN = 1'b1; dmemaddr = 32'h0000_0800;
    adv();
    settle();
    chk("mid_ramREN", 32'(ramREN), 1);
    chk("mid_err", 32'(err), 1);
    RST = 1'b1; dmemREN = 1'b0;
    adv();
    RST = 1'b0;
    settle();
    chk("mrst_ramREN", 32'(ramREN), 0);
    chk("mrst_ramWEN", 32'(ramWEN), 0);
    chk("mrst_dhit", 32'(dhit), 0);
    chk("mrst_ihit", 32'(ihit), 0);
    chk("mrst_err", 32'(err), 0);
    chk("mrst_ramaddr", ramaddr, 0);
`ifdef IFETCH_HOLD_EN
    // Reset also clears the held fetch entry.
    imemREN = 1'b1; imemaddr = 32'h0000_0100;
    settle();
    chk("mrst_hold_ihit", 32'(ihit), 0);
    adv();
    settle();
    chk("mrst_hold_ramREN", 32'(ramREN), 1);
    imemREN = 1'b0; ramready = 1'b1;
    adv();
    ramready = 1'b0;
    adv();
`endif
    chk("sb_empty", 32'(exp_q.size()), 0);
    adv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
